piso_serializer: RTL and testbench

//  Parallel-in/serial-out transmitter; the emitting counterpart of the parallel capture Register.

---
 rtl/piso_serializer_if.sv | 30 +++
 rtl/piso_serializer.sv | 140 ++++++++++++++
 tb/tb_piso_serializer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Handshake/bus bundle for piso_serializer.
//   master : drives start, data_in, shift_en; observes serial_out, busy, done
//   slave  : the serializer itself
// Signals:
//   start      load request (acted on only when the serializer is idle)
//   data_in    WORD_LENGTH-bit word, sampled on an accepted start
//   shift_en   bit strobe, advances to the next bit
//   serial_out current serial bit
//   busy       high while a word (and parity bit, if built) is on the line
//   done       one-cycle pulse after the last bit
interface piso_serializer_if #(
    parameter int WORD_LENGTH = 8
);
    logic                   start;
    logic [WORD_LENGTH-1:0] data_in;
    logic                   shift_en;
    logic                   serial_out;
    logic                   busy;
    logic                   done;

    modport master (
        output start, data_in, shift_en,
        input  serial_out, busy, done
    );

    modport slave (
        input  start, data_in, shift_en,
        output serial_out, busy, done
    );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out transmitter.
// Captures a WORD_LENGTH-bit word on start (only while idle) and shifts it
// out one bit per shift_en strobe, reporting busy and a one-cycle done pulse.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    piso_serializer_if.slave (start, data_in, shift_en in;
//          serial_out, busy, done out)
//
// Parameters:
//   WORD_LENGTH  bits per word (>= 2)
//   LSB_FIRST    1: data_in[0] goes first; 0: data_in[WORD_LENGTH-1] first
//
// Build option:
//   PARITY_SER_EN  when defined, an even-parity bit (^word) follows the
//                  last data bit as one extra bit time before done.
//
// All outputs are decoded from the state register and shift register only,
// so there is no combinational path from any input to any output.
module piso_serializer #(
    parameter int WORD_LENGTH = 8,
    parameter bit LSB_FIRST   = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    piso_serializer_if.slave   bus
);

    localparam int CNT_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LENGTH - 1);

`ifdef PARITY_SER_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t                 state, state_next;
    logic [WORD_LENGTH-1:0] shreg, shreg_next;
    logic [CNT_W-1:0]       count, count_next;
    logic                   serial_out, busy, done;
`ifdef PARITY_SER_EN
    // Parity is taken from the word at capture time, because the shift
    // register loses bits as it empties.
    logic                   parity, parity_next;
`endif

    // Bit currently presented at the output end of the shift register.
    logic                   head_bit;
    logic [WORD_LENGTH-1:0] shreg_shifted;

    assign head_bit      = LSB_FIRST ? shreg[0] : shreg[WORD_LENGTH-1];
    assign shreg_shifted = LSB_FIRST ? {1'b0, shreg[WORD_LENGTH-1:1]}
                                     : {shreg[WORD_LENGTH-2:0], 1'b0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            shreg  <= '0;
            count  <= '0;
`ifdef PARITY_SER_EN
            parity <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            shreg  <= shreg_next;
            count  <= count_next;
`ifdef PARITY_SER_EN
            parity <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next  = state;
        shreg_next  = shreg;
        count_next  = count;
        serial_out  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
`ifdef PARITY_SER_EN
        parity_next = parity;
`endif

        case (state)
            IDLE: begin
                if (bus.start) begin
                    shreg_next  = bus.data_in;
                    count_next  = '0;
`ifdef PARITY_SER_EN
                    parity_next = ^bus.data_in;
`endif
                    state_next  = SHIFT;
                end
            end

            SHIFT: begin
                busy       = 1'b1;
                serial_out = head_bit;
                if (bus.shift_en) begin
                    if (count == LAST_BIT) begin
`ifdef PARITY_SER_EN
                        state_next = PARITY;
`else
                        state_next = DONE;
`endif
                    end else begin
                        shreg_next = shreg_shifted;
                        count_next = count + CNT_W'(1);
                    end
                end
            end

`ifdef PARITY_SER_EN
            PARITY: begin
                busy       = 1'b1;
                serial_out = parity;
                if (bus.shift_en) begin
                    state_next = DONE;
                end
            end
`endif

            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.serial_out = serial_out;
    assign bus.busy       = busy;
    assign bus.done       = done;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed testbench for piso_serializer. Two instances (LSB-first and
// MSB-first) receive identical stimulus; each cycle's outputs are compared
// against hand-derived bit streams and cycle numbers. Cycle 0 is the cycle
// in which start is presented; inputs change 1 ns after the rising edge and
// outputs are sampled on the falling edge.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PARITY_SER_EN
    localparam int DONE_CYC = W + 2;
`else
    localparam int DONE_CYC = W + 1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] data_in;
    logic         shift_en;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WORD_LENGTH(W)) if_l ();
    piso_serializer_if #(.WORD_LENGTH(W)) if_m ();

    assign if_l.start    = start;
    assign if_l.data_in  = data_in;
    assign if_l.shift_en = shift_en;
    assign if_m.start    = start;
    assign if_m.data_in  = data_in;
    assign if_m.shift_en = shift_en;

    piso_serializer #(.WORD_LENGTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (if_l)
    );

    piso_serializer #(.WORD_LENGTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (if_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy_l"}, 32'(if_l.busy), 0);
        check({tag, "_done_l"}, 32'(if_l.done), 0);
        check({tag, "_ser_l"},  32'(if_l.serial_out), 0);
        check({tag, "_busy_m"}, 32'(if_m.busy), 0);
        check({tag, "_done_m"}, 32'(if_m.done), 0);
        check({tag, "_ser_m"},  32'(if_m.serial_out), 0);
    endtask

    // Sends word d starting now (cycle 0). shift_en is held low for the
    // first stall_len cycles that bit stall_bit is on the line. If
    // inject_cyc > 0, a start with data 8'hFF is pulsed in that cycle.
    task automatic run_word(input logic [W-1:0] d, input int stall_bit, input int stall_len,
                            input int inject_cyc, input int exp_done_cyc);
        int hold;
        cyc      = 0;
        start    = 1'b1;
        data_in  = d;
        shift_en = 1'b1;
        @(negedge clk);
        check("c0_busy", 32'(if_l.busy), 0);
        for (int i = 0; i < W; i++) begin
            hold = (i == stall_bit) ? stall_len : 0;
            for (int h = 0; h <= hold; h++) begin
                next_cycle();
                start    = 1'b0;
                shift_en = (h == hold);
                if (cyc == inject_cyc) begin
                    start   = 1'b1;
                    data_in = 8'hFF;
                end
                @(negedge clk);
                check("bit_l",  32'(if_l.serial_out), 32'(d[i]));
                check("bit_m",  32'(if_m.serial_out), 32'(d[W-1-i]));
                check("busy_l", 32'(if_l.busy), 1);
                check("busy_m", 32'(if_m.busy), 1);
                check("done_l", 32'(if_l.done), 0);
            end
        end
`ifdef PARITY_SER_EN
        next_cycle();
        start    = 1'b0;
        shift_en = 1'b1;
        @(negedge clk);
        check("par_l",      32'(if_l.serial_out), 32'(^d));
        check("par_m",      32'(if_m.serial_out), 32'(^d));
        check("par_busy_l", 32'(if_l.busy), 1);
        check("par_done_l", 32'(if_l.done), 0);
`endif
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        check("done_l",     32'(if_l.done), 1);
        check("done_m",     32'(if_m.done), 1);
        check("done_busy",  32'(if_l.busy), 0);
        check("done_ser",   32'(if_l.serial_out), 0);
        check("done_cycle", 32'(cyc), 32'(exp_done_cyc));
        // No further word may start without a new start in IDLE.
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            check_idle("after");
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        data_in  = '0;
        shift_en = 1'b0;

        // Reset state
        #12;
        check_idle("rst");
        @(posedge clk);
        #3 reset = 1'b1;

        // Basic word on both bit orders, with an ignored start at cycle 4
        next_cycle();
        run_word(8'h1D, -1, 0, 0, DONE_CYC);
        next_cycle();
        run_word(8'h1D, -1, 0, 4, DONE_CYC);

        // Stall of 3 cycles on bit 2
        next_cycle();
        run_word(8'h1D, 2, 3, 0, DONE_CYC + 3);

        // Other patterns (also exercise parity when built in)
        next_cycle();
        run_word(8'h07, -1, 0, 0, DONE_CYC);
        next_cycle();
        run_word(8'hA5, -1, 0, 0, DONE_CYC);

        // Asynchronous reset in the middle of bit 5
        next_cycle();
        cyc      = 0;
        start    = 1'b1;
        data_in  = 8'h1D;
        shift_en = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            start = 1'b0;
        end
        @(negedge clk);
        check("pre_rst_busy", 32'(if_l.busy), 1);
        check("pre_rst_m",    32'(if_m.serial_out), 32'(1));
        #2 reset = 1'b0;
        #1;
        check_idle("async_rst");
        next_cycle();
        #2 reset = 1'b1;
        @(negedge clk);
        check_idle("post_rst");
        next_cycle();
        run_word(8'h96, -1, 0, 0, DONE_CYC);

        // start held high: re-accepted on the first IDLE cycle
        next_cycle();
        cyc      = 0;
        start    = 1'b1;
        data_in  = 8'h80;
        shift_en = 1'b1;
        for (int c = 1; c <= DONE_CYC; c++) next_cycle();
        @(negedge clk);
        check("b2b_done", 32'(if_l.done), 1);
        next_cycle();
        @(negedge clk);
        check("b2b_idle_busy", 32'(if_l.busy), 0);
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        check("b2b_busy",  32'(if_l.busy), 1);
        check("b2b_bit_l", 32'(if_l.serial_out), 0);
        check("b2b_bit_m", 32'(if_m.serial_out), 1);
        // Let the second word drain within a bounded window.
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 4 * W && !seen; c++) begin
                next_cycle();
                @(negedge clk);
                if (if_l.done === 1'b1) seen = 1'b1;
            end
            check("b2b_drain", 32'(seen), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
